// File: rtl/lsu.sv
// Load/store unit: one request/ack transaction per access on the data-memory
// port, with byte-lane enables, store replication and load extension.
module lsu #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [2:0]       func3,
  input  logic [width-1:0] aluResult,
  input  logic [width-1:0] storeData,
  output logic             stall,
  output logic [width-1:0] loadData,
  output logic             loadValid,
  output logic             memFault,
  output logic             dmemReq,
  output logic             dmemWe,
  output logic [width-1:0] dmemAddr,
  output logic [3:0]       dmemBe,
  output logic [width-1:0] dmemWdata,
  input  logic [width-1:0] dmemRdata,
  input  logic             dmemAck,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Handshake: dmemReq stays high with address/enables/data frozen until the
  // cycle dmemAck is sampled high; dmemAck outside REQ has no effect.
  state_t           state, state_n;
  logic             access, illegal;
  logic [3:0]       be_n;
  logic [width-1:0] wdata_n;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [width-1:0] rdata_q;
  logic [width-1:0] lane;

  assign access    = memRead | memWrite;
  assign dbg_state = state;

  always_comb begin
    illegal = 1'b0;
    if (memRead && memWrite) illegal = 1'b1;
    if (memRead && (func3 == 3'd3 || func3 == 3'd6 || func3 == 3'd7)) illegal = 1'b1;
    if (memWrite && func3 > 3'd2) illegal = 1'b1;
    if (func3[1:0] == 2'd1 && aluResult[0]) illegal = 1'b1;
    if (func3[1:0] == 2'd2 && aluResult[1:0] != 2'b00) illegal = 1'b1;
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = storeData;
    case (func3[1:0])
      2'd0: begin
        be_n    = 4'b0001 << aluResult[1:0];
        wdata_n = {4{storeData[7:0]}};
      end
      2'd1: begin
        be_n    = aluResult[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{storeData[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = storeData;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (access) state_n = illegal ? ERR : REQ;
      REQ:  if (dmemAck) state_n = DONE;
      DONE: state_n = IDLE;
      ERR:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dmemAddr  <= '0;
      dmemWe    <= 1'b0;
      dmemBe    <= 4'b0000;
      dmemWdata <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && access && !illegal) begin
        dmemAddr  <= {aluResult[width-1:2], 2'b00};
        dmemWe    <= memWrite;
        dmemBe    <= be_n;
        dmemWdata <= wdata_n;
        off_q     <= aluResult[1:0];
        f3_q      <= func3;
      end
      if (state == REQ && dmemAck && !dmemWe) rdata_q <= dmemRdata;
    end
  end

  // Shift the addressed lane down to bit 0 before extending.
  assign lane = rdata_q >> {off_q, 3'b000};

  always_comb begin
    stall     = !reset && ((state == IDLE && access) || state == REQ);
    dmemReq   = (state == REQ);
    memFault  = (state == ERR);
    loadValid = (state == DONE) && !dmemWe;
    loadData  = '0;
    if (loadValid) begin
      case (f3_q)
        3'd0:    loadData = {{(width-8){lane[7]}}, lane[7:0]};
        3'd1:    loadData = {{(width-16){lane[15]}}, lane[15:0]};
        3'd4:    loadData = {{(width-8){1'b0}}, lane[7:0]};
        3'd5:    loadData = {{(width-16){1'b0}}, lane[15:0]};
        default: loadData = lane;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed accesses from the usage scenarios plus random ones,
// with load/fault results matched against an expected queue.
module tb_lsu;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [2:0]  func3;
  logic [31:0] aluResult, storeData;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid, memFault;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata, dmemRdata;
  logic        dmemAck;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  lsu #(.width(32)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .func3(func3), .aluResult(aluResult), .storeData(storeData),
    .stall(stall), .loadData(loadData), .loadValid(loadValid),
    .memFault(memFault), .dmemReq(dmemReq), .dmemWe(dmemWe),
    .dmemAddr(dmemAddr), .dmemBe(dmemBe), .dmemWdata(dmemWdata),
    .dmemRdata(dmemRdata), .dmemAck(dmemAck), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every loadValid or memFault pulse consumes one expected entry.
  always @(negedge clk) begin
    if (loadValid || memFault) begin
      check("excl", {63'd0, loadValid & memFault}, 64'd0);
      if (exp_q.size() == 0) check("unexpected_out", {31'd0, memFault, loadData}, 64'h1_0000_0000_0000);
      else check("result", {31'd0, memFault, loadData}, {31'd0, exp_q.pop_front()});
    end
  end

  // Reference behaviour written byte-wise.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] rdata, output logic ok,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] ld);
    logic [7:0] b [4];
    int o, n;
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    o  = int'(addr[1:0]);
    ok = 1'b1;
    if (rd && wr) ok = 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ok = 1'b0;
    if (wr && f3 > 3'd2) ok = 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) ok = 1'b0;
    if (f3 == 3'd2 && addr[1:0] != 2'b00) ok = 1'b0;
    n  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    be = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= o && i < o + n) be[i] = 1'b1;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % n) +: 8];
    ld = 32'd0;
    case (f3)
      3'd0: ld = {{24{b[o][7]}}, b[o]};
      3'd4: ld = {24'd0, b[o]};
      3'd1: if (o < 3) ld = {{16{b[o+1][7]}}, b[o+1], b[o]};
      3'd5: if (o < 3) ld = {16'd0, b[o+1], b[o]};
      default: ld = rdata;
    endcase
  endfunction

  // One access; when use_x is set the supplied constants replace the model.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input int k, input logic use_x,
                        input logic [3:0] xbe, input logic [31:0] xwd,
                        input logic [31:0] xld);
    logic ok;
    logic [3:0] be;
    logic [31:0] wd, ld;
    int scnt;
    model(rd, wr, f3, addr, sd, rdata, ok, be, wd, ld);
    if (use_x) begin be = xbe; wd = xwd; ld = xld; end
    if (!ok) exp_q.push_back({1'b1, 32'd0});
    else if (rd) exp_q.push_back({1'b0, ld});
    memRead = rd; memWrite = wr; func3 = f3; aluResult = addr; storeData = sd;
    #1;
    check("stall_T", {63'd0, stall}, 64'd1);
    check("req_T", {63'd0, dmemReq}, 64'd0);
    scnt = 1;
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0; aluResult = $urandom; storeData = $urandom;
    if (!ok) begin
      check("err_stall", {63'd0, stall}, 64'd0);
      check("err_req", {63'd0, dmemReq}, 64'd0);
      check("err_state", {62'd0, dbg_state}, {62'd0, S_ERR});
      @(posedge clk); #1;
      check("err_back_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
      check("err_once", {63'd0, memFault}, 64'd0);
    end else begin
      for (int i = 0; i <= k; i++) begin
        check("req", {63'd0, dmemReq}, 64'd1);
        check("we", {63'd0, dmemWe}, {63'd0, wr});
        check("addr", {32'd0, dmemAddr}, {32'd0, addr[31:2], 2'b00});
        check("be", {60'd0, dmemBe}, {60'd0, be});
        if (wr) check("wdata", {32'd0, dmemWdata}, {32'd0, wd});
        if (stall) scnt++;
        dmemAck = (i == k);
        dmemRdata = (i == k) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      dmemAck = 1'b0; dmemRdata = $urandom;
      check("done_state", {62'd0, dbg_state}, {62'd0, S_DONE});
      check("done_stall", {63'd0, stall}, 64'd0);
      check("done_req", {63'd0, dmemReq}, 64'd0);
      check("done_valid", {63'd0, loadValid}, {63'd0, rd});
      check("stall_cycles", 64'(scnt), 64'(k + 2));
      @(posedge clk); #1;
      check("back_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; memRead = 1'b1; memWrite = 1'b0; func3 = 3'd2;
    aluResult = 32'h100; storeData = 32'h0; dmemRdata = 32'h0; dmemAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_req", {63'd0, dmemReq}, 64'd0);
    check("rst_we", {63'd0, dmemWe}, 64'd0);
    check("rst_addr", {32'd0, dmemAddr}, 64'd0);
    check("rst_be", {60'd0, dmemBe}, 64'd0);
    check("rst_wdata", {32'd0, dmemWdata}, 64'd0);
    check("rst_ldata", {32'd0, loadData}, 64'd0);
    check("rst_flags", {62'd0, loadValid, memFault}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
    memRead = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Ack outside REQ does nothing.
    dmemAck = 1'b1;
    @(posedge clk); #1;
    dmemAck = 1'b0;
    check("idle_ack_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("idle_ack_req", {63'd0, dmemReq}, 64'd0);

    access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 4'hF, 32'h0, 32'hDEADBEEF);
    access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 0, 1, 4'b1000, 32'h0, 32'hFFFFFF80);
    access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 1, 1, 4'b1000, 32'h0, 32'h00000080);
    access(0, 1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 0, 1, 4'b1100, 32'hABCDABCD, 32'h0);
    access(1, 0, 3'd1, 32'h302, 32'h0, 32'h8001_7F00, 0, 1, 4'b1100, 32'h0, 32'hFFFF8001);
    access(1, 0, 3'd5, 32'h302, 32'h0, 32'h8001_7F00, 2, 1, 4'b1100, 32'h0, 32'h00008001);
    access(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    access(0, 1, 3'd0, 32'h7, 32'h0000005A, 32'h0, 3, 1, 4'b1000, 32'h5A5A5A5A, 32'h0);
    access(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    access(0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    access(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    access(0, 1, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    access(0, 1, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Reset during REQ, then a late ack.
    memRead = 1'b1; func3 = 3'd2; aluResult = 32'h400;
    @(posedge clk); #1;
    memRead = 1'b0;
    check("rreq_req", {63'd0, dmemReq}, 64'd1);
    reset = 1'b1;
    #1;
    check("rreq_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rreq_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("rreq_req_low", {63'd0, dmemReq}, 64'd0);
    dmemAck = 1'b1; dmemRdata = 32'h12345678;
    @(posedge clk); #1;
    dmemAck = 1'b0;
    check("rreq_late_ack", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("rreq_flags", {61'd0, dmemReq, loadValid, memFault}, 64'd0);
    @(posedge clk); #1;
    check("rreq_flags2", {61'd0, dmemReq, loadValid, memFault}, 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic rd, wr;
      int r;
      r = $urandom_range(0, 9);
      rd = (r == 0) || (r < 6);
      wr = (r == 0) || (r >= 6);
      access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), 0, 4'h0, 32'h0, 32'h0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the execute-to-memory boundary of the RISC-V core. It consumes the ALU's address result, the store operand and the instruction's func3. It runs a single request/acknowledge transaction on the data-memory port, then returns a sign- or zero-extended load value. While the transaction is in flight it asserts `stall` so the pipeline holds.

## Interface
- `width`, 32: data and address width; only 32 is supported.
- `clk`  in  1  rising-edge clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `memRead`  in  1  the current instruction is a load.
- `memWrite`  in  1  the current instruction is a store.
- `func3`  in  3  load/store size and sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `aluResult`  in  width  byte address from the ALU.
- `storeData`  in  width  store operand (rs2).
- `stall`  out  1  holds the upstream pipeline.
- `loadData`  out  width  extended load result.
- `loadValid`  out  1  `loadData` is valid this cycle.
- `memFault`  out  1  one-cycle pulse on a misaligned or illegal access.
- `dmemReq`  out  1  memory request.
- `dmemWe`  out  1  1 = write, 0 = read.
- `dmemAddr`  out  width  word address; bits [1:0] are always 0.
- `dmemBe`  out  4  byte enables.
- `dmemWdata`  out  width  lane-replicated store data.
- `dmemRdata`  in  width  read data; sampled only in the cycle `dmemAck` is high.
- `dmemAck`  in  1  the memory has completed the request.

## Operation
- The FSM has four states: IDLE, REQ, DONE, ERR. Reset places it in IDLE.
- **IDLE**
  - A new access is `memRead | memWrite`. When one is present, `stall` is 1 combinationally in that cycle.
  - An access is illegal in any of these cases:
    - both `memRead` and `memWrite` are 1;
    - a load has func3 of 3, 6 or 7;
    - a store has func3 other than 0–2;
    - a halfword access has `aluResult[0]` = 1;
    - a word access has `aluResult[1:0]` != 0.
  - An illegal access moves the FSM to ERR. A legal access moves it to REQ.
  - On the move to REQ the block registers:
    - `dmemAddr` = {`aluResult[31:2]`, 2'b00};
    - `dmemWe` = `memWrite`;
    - the byte offset, func3 and `dmemBe`.
  - Byte enables: B → 4'b0001 << `aluResult[1:0]`; H → 4'b0011 when `aluResult[1]` = 0, else 4'b1100; W → 4'b1111. Loads use the same enables.
  - Store data: B → `storeData[7:0]` replicated ×4; H → `storeData[15:0]` replicated ×2; W → `storeData` unchanged.
- **REQ**
  - `dmemReq` = 1, `stall` = 1.
  - The address, enables, write data and `dmemWe` stay stable until acknowledged.
  - When `dmemAck` = 1, the FSM moves to DONE. For a load it also captures `dmemRdata`.
- **DONE** (one cycle)
  - `stall` = 0 and `dmemReq` = 0. The FSM moves to IDLE.
  - Inputs are ignored in this cycle, because they still describe the instruction just completed.
  - For a load, `loadValid` = 1 and `loadData` is the extracted lane:
    - B and H are sign-extended from bit 7 or bit 15;
    - BU and HU are zero-extended;
    - W is passed unchanged.
  - For a store, `loadValid` = 0.
- **ERR** (one cycle)
  - `memFault` = 1 and `stall` = 0. The FSM moves to IDLE.
  - No memory request is issued.
- `dmemAck` is ignored in every state other than REQ.

## Timing
- Reset values:
  - `dmemReq`, `dmemWe`, `dmemAddr`, `dmemBe`, `dmemWdata`, `loadData`, `loadValid` and `memFault` are all 0.
  - `stall` is forced to 0 while `reset` is high.
- Legal access accepted in IDLE at cycle T:
  - `dmemReq` rises at T+1.
  - If the ack arrives at T+1+k, DONE is at T+2+k.
  - `stall` is high from T through T+1+k.
  - Best case (k = 0): 2 stall cycles, with the result at T+2.
- Illegal access at T: `stall` is high at T, ERR is at T+1, and `memFault` pulses at T+1.
- Reset asserted in REQ: the FSM is in IDLE at the next edge, `dmemReq` is 0 from then on, and no `loadValid` or `memFault` is produced. A late `dmemAck` is ignored.
- `loadValid` and `memFault` are never both high in the same cycle.
- Back-to-back accesses: the next instruction is accepted only in IDLE, so there is at least one idle cycle (the DONE cycle) between transactions.

## Test plan
- LW at address 0x100; the memory acks at the first REQ cycle with 0xDEADBEEF.
  - `dmemAddr` = 0x100, `dmemBe` = 4'hF.
  - `stall` is high for 2 cycles, then `loadValid` = 1 with `loadData` = 0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, both with `dmemRdata` = 0x80FF1234.
  - Both: `dmemBe` = 4'b1000.
  - LB: `loadData` = 0xFFFFFF80. LBU: `loadData` = 0x00000080.
- SH at 0x202 with `storeData` = 0x0000ABCD.
  - `dmemWe` = 1, `dmemAddr` = 0x200, `dmemBe` = 4'b1100, `dmemWdata` = 0xABCDABCD.
  - `loadValid` stays 0.
- LW at 0x101: no `dmemReq`; `memFault` pulses for 1 cycle at T+1; `stall` is high at T only.
- SB to 0x7 with the ack delayed 3 cycles.
  - `dmemReq`, `dmemAddr`, `dmemBe` = 4'b1000 and `dmemWdata` hold stable across all 4 REQ cycles.
  - `stall` is high for 5 cycles.
- `reset` pulsed during REQ, then an ack arrives one cycle later: `dmemReq` drops, the FSM is in IDLE, and `loadValid` and `memFault` stay 0.
